// File: rtl/fpu_normalize.sv
// fpu_normalize: make the hidden bit explicit and normalize subnormals to leading-1 form with a widened signed exponent.
// Ports: clk, rst (sync, active-high); in_valid/in_ready plus in_sign/in_exponent/in_significand/in_is_* class flags;
// out_valid/out_ready plus out_sign/out_exponent (signed, still biased)/out_significand (explicit bit at [S])/out_is_*.
// FPU_NORM_FAST_EN: normalize subnormals in the accept cycle (leading-zero count + barrel shift); default is one bit per cycle.
module fpu_normalize #(
  parameter int SIGN_WIDTH = 1,
  parameter int EXPONENT_WIDTH = 11,
  parameter int SIGNIFICAND_WIDTH = 52,
  localparam int XW = ((EXPONENT_WIDTH > $clog2(SIGNIFICAND_WIDTH + 1)) ? EXPONENT_WIDTH : $clog2(SIGNIFICAND_WIDTH + 1)) + 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SIGN_WIDTH-1:0]         in_sign,
  input  logic [EXPONENT_WIDTH-1:0]     in_exponent,
  input  logic [SIGNIFICAND_WIDTH-1:0]  in_significand,
  input  logic                          in_is_zero,
  input  logic                          in_is_subnormal,
  input  logic                          in_is_inf,
  input  logic                          in_is_nan,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SIGN_WIDTH-1:0]         out_sign,
  output logic signed [XW-1:0]          out_exponent,
  output logic [SIGNIFICAND_WIDTH:0]    out_significand,
  output logic                          out_is_zero,
  output logic                          out_is_subnormal,
  output logic                          out_is_inf,
  output logic                          out_is_nan
);
  localparam int S = SIGNIFICAND_WIDTH;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [SIGN_WIDTH-1:0] sign_n;
  logic signed [XW-1:0] exp_n;
  logic [S:0] sig_n;
  logic [3:0] flags_n;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
`ifdef FPU_NORM_FAST_EN
  logic [XW-1:0] lz;
  // scanning upward lets the highest set bit win
  always_comb begin
    lz = '0;
    for (int i = 0; i < S; i++)
      if (in_significand[i]) lz = XW'(S - i);
  end
`endif
  always_comb begin
    state_n = state;
    sign_n = out_sign;
    exp_n = out_exponent;
    sig_n = out_significand;
    flags_n = {out_is_nan, out_is_inf, out_is_zero, out_is_subnormal};
    if (state == IDLE && in_valid) begin
      sign_n = in_sign;
      flags_n = {in_is_nan, in_is_inf, in_is_zero, in_is_subnormal};
      state_n = DONE;
      if (in_is_nan || in_is_inf) begin
        exp_n = XW'(in_exponent);
        sig_n = {1'b0, in_significand};
      end else if (in_is_zero) begin
        exp_n = '0;
        sig_n = '0;
      end else if (in_is_subnormal) begin
`ifdef FPU_NORM_FAST_EN
        exp_n = XW'(1) - lz;
        sig_n = {1'b0, in_significand} << lz;
`else
        exp_n = XW'(1);
        sig_n = {1'b0, in_significand};
        state_n = SHIFT;
`endif
      end else begin
        exp_n = XW'(in_exponent);
        sig_n = {1'b1, in_significand};
      end
    end else if (state == SHIFT) begin
      sig_n = out_significand << 1;
      exp_n = out_exponent - XW'(1);
      state_n = out_significand[S-1] ? DONE : SHIFT;
    end else if (state == DONE) begin
      state_n = out_ready ? IDLE : DONE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_sign <= '0;
      out_exponent <= '0;
      out_significand <= '0;
      {out_is_nan, out_is_inf, out_is_zero, out_is_subnormal} <= '0;
    end else begin
      state <= state_n;
      out_sign <= sign_n;
      out_exponent <= exp_n;
      out_significand <= sig_n;
      {out_is_nan, out_is_inf, out_is_zero, out_is_subnormal} <= flags_n;
    end
  end
endmodule
